backing_memory_responder: RTL and testbench
===========================================

Name: backing_memory_responder

Overview:
- Main-memory responder on the refill side of the L1 data cache. The cache controller is the initiator; this block is the multi-cycle memory behind it.
- Serves two request types:
  - Block reads for line refills, returned as a burst of one word per cycle.
  - Single-word write-through writes, confirmed by an acknowledge pulse.
- Models a fixed access latency so the cache stall path is exercised against realistic timing.

Parameters:
- ADDR_WIDTH, 10, word-address width; the array holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- WORDS_PER_BLOCK, 4, beats per refill burst; must be a power of two, at least 2.
- LATENCY, 4, cycles from request acceptance to first read beat or write commit; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  in  1  request strobe; sampled only while busy=0.
- mem_we  in  1  1 = single-word write, 0 = block read; sampled with mem_req.
- mem_addr  in  ADDR_WIDTH  word address; low log2(WORDS_PER_BLOCK) bits are ignored for reads.
- mem_wdata  in  DATA_WIDTH  write data; sampled with mem_req.
- busy  out  1  high from the acceptance edge until the transaction completes.
- mem_rdata  out  DATA_WIDTH  read beat data; valid only while mem_rvalid=1.
- mem_rvalid  out  1  read beat valid.
- mem_last  out  1  high with the final beat of a burst.
- mem_wack  out  1  one-cycle write-commit acknowledge.

Behaviour:
- Reset (asynchronous, any time):
  - State forced to IDLE.
  - busy, mem_rvalid, mem_last, mem_wack = 0; mem_rdata = 0.
  - All array words cleared to 0.
  - Latched address, data and counters cleared.
  - An in-flight write is discarded and an in-flight burst is aborted; no partial beats follow reset release.
- FSM states: IDLE, WAIT, BURST, WACK.
- IDLE:
  - busy=0.
  - At an edge E0 with mem_req=1: latch mem_we, mem_addr and mem_wdata; load the latency counter with LATENCY-1; go to WAIT; busy=1 from E0.
- Requests while busy=1 are ignored: no latching, no queueing, no side effect. The initiator must re-present them once busy=0.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0 (edge E0+LATENCY), go to BURST if read, or WACK if write.
- Read path (BURST):
  - Base address = latched address with its low log2(WORDS_PER_BLOCK) bits zeroed.
  - Beat i (i = 0..WORDS_PER_BLOCK-1) is presented in the cycle following edge E0+LATENCY+i:
    - mem_rdata = array[base+i], mem_rvalid=1.
    - mem_last=1 only on beat WORDS_PER_BLOCK-1.
  - Beat index is a wrap-free up-counter: base is aligned, so base+i never crosses the block boundary.
  - At edge E0+LATENCY+WORDS_PER_BLOCK: mem_rvalid=0, mem_last=0, busy=0, state IDLE.
  - Read latency to first beat = LATENCY cycles; total occupancy = LATENCY+WORDS_PER_BLOCK cycles.
- Write path (WACK):
  - array[latched address] <= latched data at edge E0+LATENCY.
  - mem_wack=1 for exactly the following cycle.
  - At edge E0+LATENCY+1: mem_wack=0, busy=0, state IDLE.
  - Total occupancy = LATENCY+1 cycles.
- Back-to-back: a request held high across the completion edge is accepted at the first edge where busy=0. That is one idle cycle minimum between transactions; busy is registered, not combinational.
- Read-after-write to the same word, issued after mem_wack, returns the new data.
- mem_rdata is registered; it holds its last value outside beats, and only mem_rvalid qualifies it.
- mem_rvalid and mem_wack are never high together.

Test Plan:
- Reset then read: rst pulse, mem_req=1, mem_we=0, mem_addr=0x005 at E0 (LATENCY=4, WORDS_PER_BLOCK=4) -> busy rises at E0; four beats of 0x00000000 in the cycles after E0+4..E0+7; mem_last on beat 3; busy low after E0+8.
- Write then refill:
  - Write 0xDEADBEEF to 0x006 -> mem_wack for exactly one cycle after E0+4; busy low after E0+5.
  - Then read 0x004 -> beats 0,0,0xDEADBEEF,0, with mem_last on the 4th beat.
- Request while busy: second mem_req (write 0x11111111 to 0x006) asserted during WAIT of a read -> ignored; a subsequent read of block 0x004 shows the old word.
- Held request back-to-back: mem_req held high through two reads of 0x3F8 and 0x3FC -> second accepted at the first edge with busy=0; first beats exactly LATENCY+WORDS_PER_BLOCK+1 cycles apart; top block returns words 0x3FC..0x3FF without address wrap.
- Async reset mid-burst: assert rst between beat 1 and beat 2 -> mem_rvalid, mem_last and busy drop immediately without waiting for a clock edge; no further beats after release; array reads back 0.
- Async reset mid-write: assert rst during WAIT of a write to 0x010 -> no mem_wack; a later read of 0x010 returns 0.

Source files
------------

// File: rtl/backing_memory_responder.sv
// Fixed-latency main-memory responder behind the L1 data cache refill path.
// Serves aligned block-read bursts and single-word write-through writes.
module backing_memory_responder #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  mem_last,
  output logic                  mem_wack
);

  localparam int unsigned BEAT_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

  state_t                  state, next_state;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [CNT_W-1:0]        lat_cnt;
  logic [BEAT_W-1:0]       beat;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    lat_done;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Base is block-aligned, so OR-ing in the beat index never carries out of the block.
  assign rd_addr  = (lat_addr & ~ADDR_WIDTH'(WORDS_PER_BLOCK - 1)) | ADDR_WIDTH'(beat);
  assign lat_done = (lat_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_req) next_state = WAIT;
      WAIT:    if (lat_done) next_state = lat_we ? WACK : BURST;
      BURST:   if (mem_last) next_state = IDLE;
      WACK:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_last   <= 1'b0;
      mem_wack   <= 1'b0;
      mem_rdata  <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_cnt    <= '0;
      beat       <= '0;
    end else begin
      busy       <= (next_state != IDLE);
      mem_rvalid <= (next_state == BURST);
      mem_wack   <= (next_state == WACK);
      case (state)
        IDLE: begin
          if (mem_req) begin
            lat_we   <= mem_we;
            lat_addr <= mem_addr;
            lat_data <= mem_wdata;
            lat_cnt  <= CNT_W'(LATENCY - 1);
            beat     <= '0;
          end
        end
        WAIT: begin
          if (!lat_done) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else if (!lat_we) begin
            mem_rdata <= mem[rd_addr];
            mem_last  <= 1'b0;
            beat      <= beat + 1'b1;
          end
        end
        BURST: begin
          if (!mem_last) begin
            mem_rdata <= mem[rd_addr];
            mem_last  <= (beat == BEAT_W'(WORDS_PER_BLOCK - 1));
            beat      <= beat + 1'b1;
          end else begin
            mem_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == WAIT && lat_done && lat_we) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_backing_memory_responder.sv
// Directed bench for backing_memory_responder: a transaction-level timing model
// is compared against the DUT every cycle, plus literal checks on key results.
module tb_backing_memory_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = 4;
  localparam int unsigned L  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          busy, mem_rvalid, mem_last, mem_wack;
  logic [DW-1:0] mem_rdata;

  backing_memory_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(W), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_last(mem_last),
    .mem_wack(mem_wack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: one outstanding transaction timed from its acceptance edge.
  logic [DW-1:0] m_mem [1 << AW];
  bit            m_active;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_t0;
  bit            e_busy, e_rvalid, e_last, e_wack;
  logic [DW-1:0] e_rdata;

  int            cyc = 0;
  logic [DW-1:0] beats[$];
  int            beat_cyc[$];
  int            last_at;
  int            wacks;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    m_active = 0; m_wr = 0; m_addr = '0; m_data = '0; m_t0 = 0;
    e_busy = 0; e_rvalid = 0; e_last = 0; e_wack = 0; e_rdata = '0;
  endtask

  task automatic model_edge();
    bit was;
    int k;
    was = m_active;
    if (m_active) begin
      k = cyc - m_t0;
      if (m_wr && k == L) m_mem[m_addr] = m_data;
      if (k == (m_wr ? L + 1 : L + W)) m_active = 0;
    end
    if (!was && mem_req) begin
      m_active = 1; m_wr = mem_we; m_addr = mem_addr; m_data = mem_wdata; m_t0 = cyc;
    end
    k = cyc - m_t0;
    e_busy   = m_active;
    e_rvalid = m_active && !m_wr && k >= L && k < L + W;
    e_last   = e_rvalid && k == L + W - 1;
    e_wack   = m_active && m_wr && k == L;
    if (e_rvalid) e_rdata = m_mem[(m_addr & ~AW'(W - 1)) + AW'(k - L)];
  endtask

  task automatic compare();
    check("busy",   busy,       e_busy);
    check("rvalid", mem_rvalid, e_rvalid);
    check("last",   mem_last,   e_last);
    check("wack",   mem_wack,   e_wack);
    check("rdata",  mem_rdata,  e_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) model_edge();
    @(negedge clk);
    compare();
    if (mem_rvalid) begin
      beats.push_back(mem_rdata);
      beat_cyc.push_back(cyc);
      if (mem_last) last_at = beats.size();
    end
    if (mem_wack) wacks++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    beats.delete(); beat_cyc.delete(); last_at = 0; wacks = 0;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = d;
    step();
    mem_req = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d);
    run(L + 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    clear_log();
    issue(1'b0, a, '0);
    run(L + W);
  endtask

  initial begin
    model_clear();
    run(2);
    rst = 0;
    run(2);
    check("reset_busy", busy, 1'b0);
    check("reset_rdata", mem_rdata, 32'h0);

    // Reset then read
    clear_log();
    issue(1'b0, 10'h005, '0);
    check("read_busy_at_e0", busy, 1'b1);
    run(L + W);
    check("read0_nbeats", beats.size(), 4);
    check("read0_beat3", beats[3], 32'h0);
    check("read0_last_on_4th", last_at, 4);
    check("read0_busy_done", busy, 1'b0);

    // Write then refill
    clear_log();
    issue(1'b1, 10'h006, 32'hDEADBEEF);
    run(L);
    check("wack_pulse", mem_wack, 1'b1);
    step();
    check("wack_low", mem_wack, 1'b0);
    check("write_busy_done", busy, 1'b0);
    check("wack_count", wacks, 1);
    do_read(10'h004);
    check("refill_beat0", beats[0], 32'h0);
    check("refill_beat2", beats[2], 32'hDEADBEEF);
    check("refill_beat3", beats[3], 32'h0);
    check("refill_last", last_at, 4);

    // Request while busy is ignored
    clear_log();
    issue(1'b0, 10'h004, '0);
    mem_req = 1; mem_we = 1; mem_addr = 10'h006; mem_wdata = 32'h11111111;
    run(2);
    mem_req = 0;
    run(L + W - 2);
    check("ignored_no_wack", wacks, 0);
    do_read(10'h004);
    check("ignored_old_word", beats[2], 32'hDEADBEEF);

    // Held request back-to-back over the top block
    for (int i = 0; i < 4; i++) do_write(AW'(10'h3FC + i), 32'hA0000000 + i);
    clear_log();
    mem_req = 1; mem_we = 0; mem_addr = 10'h3F8;
    step();
    mem_addr = 10'h3FC;
    run(L + W + 1);
    mem_req = 0;
    run(L + W);
    check("b2b_nbeats", beats.size(), 8);
    check("b2b_spacing", beat_cyc[4] - beat_cyc[0], L + W + 1);
    check("b2b_first_block", beats[0], 32'h0);
    check("top_word0", beats[4], 32'hA0000000);
    check("top_word3", beats[7], 32'hA0000003);

    // Async reset mid-burst
    do_write(10'h005, 32'h12345678);
    clear_log();
    issue(1'b0, 10'h004, '0);
    run(L + 1);
    #1 rst = 1;
    model_clear();
    #1;
    check("async_rvalid", mem_rvalid, 1'b0);
    check("async_last", mem_last, 1'b0);
    check("async_busy", busy, 1'b0);
    run(2);
    rst = 0;
    run(6);
    check("no_beats_after_rst", beats.size(), 2);
    do_read(10'h004);
    check("cleared_word", beats[1], 32'h0);

    // Async reset mid-write
    clear_log();
    issue(1'b1, 10'h010, 32'hCAFEF00D);
    run(2);
    #1 rst = 1;
    model_clear();
    run(2);
    rst = 0;
    run(6);
    check("no_wack_after_rst", wacks, 0);
    do_read(10'h010);
    check("discarded_write", beats[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
